ps2_scancode_rx: RTL and testbench



---
 rtl/ps2_pkg.sv | 36 +++
 rtl/ps2_frame_rx.sv | 120 ++++++++++++
 rtl/ps2_scancode_rx.sv | 83 ++++++++
 tb/tb_ps2_scancode_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 set-2 scan-code receiver.
// Prefix bytes, keyboard response codes and the frame FSM state encoding.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    // Keyboard responses that never represent a key.
    localparam logic [7:0] PS2_RSP_ERR0   = 8'h00;
    localparam logic [7:0] PS2_RSP_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_RSP_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RSP_BAT_F0 = 8'hFC;
    localparam logic [7:0] PS2_RSP_BAT_F1 = 8'hFD;
    localparam logic [7:0] PS2_RSP_RESEND = 8'hFE;
    localparam logic [7:0] PS2_RSP_ERR1   = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK
    } frame_state_t;

    function automatic logic is_response(input logic [7:0] code);
        case (code)
            PS2_RSP_ERR0, PS2_RSP_BAT_OK, PS2_RSP_ECHO, PS2_RSP_ACK,
            PS2_RSP_BAT_F0, PS2_RSP_BAT_F1, PS2_RSP_RESEND, PS2_RSP_ERR1:
                is_response = 1'b1;
            default:
                is_response = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, clock glitch filter, 11-bit frame FSM
// and inter-edge timeout. Emits a one-cycle strobe per good byte.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       err_parity,
    output logic       err_timeout
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic          clk_filt_q;
    logic [FW-1:0] filt_cnt_q;
    logic          filt_flip;
    logic          fall;

    // Bit [1] of each synchroniser is the usable synced sample.
    assign filt_flip = (clk_sync_q[1] != clk_filt_q) && (filt_cnt_q == FW'(FILTER_LEN - 1));
    assign fall      = filt_flip && clk_filt_q;

    always_ff @(posedge clk_sys) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_filt_q  <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            if (clk_sync_q[1] == clk_filt_q || filt_flip)
                filt_cnt_q <= '0;
            else
                filt_cnt_q <= filt_cnt_q + 1'b1;
            if (filt_flip)
                clk_filt_q <= ~clk_filt_q;
        end
    end

    frame_state_t  state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          frame_ok;

    // shift_q holds {stop, parity, data[7:0]} once all ten bits are in.
    assign frame_ok  = (^shift_q[8:0]) && shift_q[9];
    assign byte_data = shift_q[7:0];

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no latch can be inferred.
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tmo_cnt_d   = tmo_cnt_q;
        byte_valid  = 1'b0;
        err_parity  = 1'b0;
        err_timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmo_cnt_d = '0;
                if (fall && !data_sync_q[1]) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (fall) begin
                    shift_d   = {data_sync_q[1], shift_q[9:1]};
                    tmo_cnt_d = '0;
                    if (bit_cnt_q == 4'd9)
                        state_d = ST_CHECK;
                    else
                        bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                    err_timeout = 1'b1;
                    tmo_cnt_d   = '0;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (frame_ok)
                    byte_valid = 1'b1;
                else
                    err_parity = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 set-2 scan-code receiver: decodes E0/F0/E1 prefixes of good bytes into
// registered single-cycle key events for the keyboard matrix.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_strobe,
    output logic       key_pressed,
    output logic       key_extended,
    output logic [7:0] key_code,
    output logic       err_parity,
    output logic       err_timeout
);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err_parity;
    logic       frame_err_timeout;
    logic       ext_q;
    logic       brk_q;
    logic [2:0] skip_q;

    ps2_frame_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_frame (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .err_parity  (frame_err_parity),
        .err_timeout (frame_err_timeout)
    );

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            key_strobe   <= 1'b0;
            key_pressed  <= 1'b0;
            key_extended <= 1'b0;
            key_code     <= '0;
            err_parity   <= 1'b0;
            err_timeout  <= 1'b0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            skip_q       <= '0;
        end else begin
            key_strobe  <= 1'b0;
            err_parity  <= frame_err_parity;
            err_timeout <= frame_err_timeout;
            if (frame_err_parity || frame_err_timeout) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (byte_valid) begin
                if (skip_q != '0) begin
                    skip_q <= skip_q - 3'd1;
                end else if (byte_data == PS2_PAUSE) begin
                    skip_q <= PAUSE_SKIP;
                end else if (byte_data == PS2_EXT) begin
                    ext_q <= 1'b1;
                end else if (byte_data == PS2_BRK) begin
                    brk_q <= 1'b1;
                end else if (!(is_response(byte_data) && !ext_q && !brk_q)) begin
                    // Response bytes are only dropped when no prefix is pending.
                    key_strobe   <= 1'b1;
                    key_code     <= byte_data;
                    key_pressed  <= ~brk_q;
                    key_extended <= ext_q;
                    ext_q        <= 1'b0;
                    brk_q        <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Self-checking bench for ps2_scancode_rx: directed scenarios plus random key
// actions encoded as set-2 byte streams, compared to the intended key events.
`timescale 1ns/1ps
module tb_ps2_scancode_rx;
    import ps2_pkg::*;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 1000;
    localparam int HALF       = 16;
    localparam int GAP        = 48;

    logic       clk_sys  = 1'b0;
    logic       reset_n  = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_strobe;
    logic       key_pressed;
    logic       key_extended;
    logic [7:0] key_code;
    logic       err_parity;
    logic       err_timeout;

    always #5 clk_sys = ~clk_sys;

    ps2_scancode_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .key_strobe   (key_strobe),
        .key_pressed  (key_pressed),
        .key_extended (key_extended),
        .key_code     (key_code),
        .err_parity   (err_parity),
        .err_timeout  (err_timeout)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Events are packed as {code, pressed, extended}.
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    int par_cnt = 0, tmo_cnt = 0, exp_par = 0, exp_tmo = 0;
    int overlap_cnt = 0, wide_cnt = 0;
    logic prev_strobe = 1'b0, prev_par = 1'b0, prev_tmo = 1'b0;

    logic [7:0] rsp_list [8] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    logic [7:0] pause_seq[8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    always @(negedge clk_sys) begin
        if (key_strobe) got_q.push_back({key_code, key_pressed, key_extended});
        if (err_parity) par_cnt++;
        if (err_timeout) tmo_cnt++;
        if (int'(key_strobe) + int'(err_parity) + int'(err_timeout) > 1) overlap_cnt++;
        if ((key_strobe && prev_strobe) || (err_parity && prev_par) || (err_timeout && prev_tmo))
            wide_cnt++;
        prev_strobe = key_strobe;
        prev_par    = err_parity;
        prev_tmo    = err_timeout;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            ticks(HALF);
            ps2_clk = 1'b0;
            ticks(HALF);
            ps2_clk = 1'b1;
        end
        ticks(HALF);
        ps2_data = 1'b1;
        ticks(GAP);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic p;
        p = ~(^b);
        if (bad_par) p = ~p;
        send_bits({~bad_stop, p, b, 1'b0}, 11);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0);
    endtask

    // Encode one intended key action and record the event it must produce.
    task automatic key_action(input logic [7:0] code, input bit ext, input bit brk, input bit swap);
        if (ext && brk && swap) begin
            send_byte(PS2_BRK);
            send_byte(PS2_EXT);
        end else begin
            if (ext) send_byte(PS2_EXT);
            if (brk) send_byte(PS2_BRK);
        end
        send_byte(code);
        exp_q.push_back({code, ~brk, ext});
    endtask

    task automatic compare(input string tag);
        logic [9:0] last;
        ticks(40);
        check({tag, ":count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, ":event"}, 32'(got_q[i]), 32'(exp_q[i]));
        check({tag, ":err_parity"}, 32'(par_cnt), 32'(exp_par));
        check({tag, ":err_timeout"}, 32'(tmo_cnt), 32'(exp_tmo));
        if (exp_q.size() > 0) begin
            last = exp_q[exp_q.size() - 1];
            check({tag, ":held_code"}, 32'(key_code), 32'(last[9:2]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int k;
        logic [7:0] code;

        reset_n = 1'b0;
        ticks(5);
        check("rst:strobe",   32'(key_strobe),   32'(0));
        check("rst:pressed",  32'(key_pressed),  32'(0));
        check("rst:extended", 32'(key_extended), 32'(0));
        check("rst:code",     32'(key_code),     32'(0));
        check("rst:errs",     32'({err_parity, err_timeout}), 32'(0));
        reset_n = 1'b1;
        ticks(5);

        key_action(8'h1C, 1'b0, 1'b0, 1'b0);
        key_action(8'h1C, 1'b0, 1'b1, 1'b0);
        compare("make_break");

        key_action(8'h75, 1'b1, 1'b0, 1'b0);
        key_action(8'h75, 1'b1, 1'b1, 1'b0);
        key_action(8'h75, 1'b1, 1'b1, 1'b1);
        compare("extended");

        // Pending F0 must be cleared by the parity failure.
        send_byte(PS2_BRK);
        send_frame(8'h16, 1'b1, 1'b0);
        exp_par++;
        key_action(8'h16, 1'b0, 1'b0, 1'b0);
        compare("parity");

        // Pending E0 must be cleared by the timeout.
        send_byte(PS2_EXT);
        send_bits({1'b1, 1'b0, 8'h45, 1'b0}, 5);
        ticks(TIMEOUT + 100);
        exp_tmo++;
        check("timeout:state_idle", 32'(dut.u_frame.state_q), 32'(ST_IDLE));
        key_action(8'h45, 1'b0, 1'b0, 1'b0);
        compare("timeout");

        for (int i = 0; i < 8; i++) send_byte(pause_seq[i]);
        key_action(8'h29, 1'b0, 1'b0, 1'b0);
        compare("pause");

        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        ticks(3);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        ticks(40);
        send_byte(8'hFA);
        key_action(8'h1C, 1'b0, 1'b0, 1'b0);
        compare("glitch_ack");

        send_byte(PS2_EXT);
        send_bits({1'b1, 1'b0, 8'h33, 1'b0}, 5);
        reset_n = 1'b0;
        ticks(3);
        check("midreset:code", 32'(key_code), 32'(0));
        reset_n = 1'b1;
        ticks(5);
        key_action(8'h5A, 1'b0, 1'b0, 1'b0);
        compare("midreset");

        for (int it = 0; it < 30; it++) begin
            k = $urandom_range(0, 9);
            if (k <= 5 || k == 9) begin
                code = 8'($urandom_range(1, 8'h83));
                key_action(code, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)));
            end else if (k == 6) begin
                send_byte(rsp_list[$urandom_range(0, 7)]);
            end else if (k == 7) begin
                for (int i = 0; i < 8; i++) send_byte(pause_seq[i]);
            end else begin
                code = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1) send_frame(code, 1'b1, 1'b0);
                else send_frame(code, 1'b0, 1'b1);
                exp_par++;
            end
            if (it % 10 == 9) compare("random");
        end

        check("pulses_exclusive", 32'(overlap_cnt), 32'(0));
        check("pulse_width",      32'(wide_cnt),    32'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
